// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the program-counter run controller.
//   run_state_t  : sequencer states (IDLE, LOAD, FETCH, EXEC, DONE, ERR)
//   DEF_*        : default address width, counter width and fetch wait limit
package run_ctrl_pkg;

  localparam int unsigned DEF_AW       = 16;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_MAX_WAIT = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    EXEC,
    DONE,
    ERR
  } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the instruction and cycle counts.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset, clears q
//   clr    in   synchronous clear (start of a new run)
//   inc    in   add one unless already all-ones
//   q      out  count value [W-1:0]
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pc_run_controller.sv
// Run sequencer for the program counter and instruction fetch.
// On an accepted start it loads the PC with start_addr, then alternates
// FETCH (req/ack with instruction memory, PC held) and EXEC (one-cycle
// instruction strobe, PC advances unless the instruction is a halt).
// A run ends in DONE on a halt instruction or in ERR when a fetch waits
// max_wait cycles without an ack.
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   start        in   begin a run (honoured in IDLE/DONE/ERR only)
//   start_addr   in   first instruction address, captured on accepted start
//   halt_instr   in   decoded halt, meaningful while instr_valid
//   imem_ack     in   instruction memory has data for the current PC
//   imem_req     out  fetch request for the current PC
//   pc_halt      out  hold the PC this edge
//   pc_load      out  load the PC from load_addr this edge (overrides pc_halt)
//   load_addr    out  registered start address
//   instr_valid  out  fetched instruction executes this cycle
//   done         out  run ended by a halt instruction
//   timeout      out  run ended by fetch timeout
//   instr_count  out  instructions executed this run (saturating)
//   cycle_count  out  FETCH+EXEC cycles this run (saturating)
module pc_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic             halt_instr,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic             pc_halt,
  output logic             pc_load,
  output logic [AW-1:0]    load_addr,
  output logic             instr_valid,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned             WAIT_W    = $clog2(MAX_WAIT + 1);
  // Value of the wait counter during the last FETCH cycle allowed before timeout.
  localparam logic [WAIT_W-1:0]       WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  run_state_t        state;
  run_state_t        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;

  // State register, captured start address and fetch wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      load_addr <= '0;
      wait_cnt  <= '0;
    end else begin
      state <= state_nxt;
      // LOAD is only ever entered through an accepted start.
      if (state_nxt == LOAD) begin
        load_addr <= start_addr;
      end
      // Zero outside FETCH so every fetch starts its wait from scratch; it can
      // reach at most MAX_WAIT before FETCH is left, so it never overflows.
      if (state == FETCH) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Next state and outputs, decoded from the registered state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt   = state;
    imem_req    = 1'b0;
    pc_halt     = 1'b1;
    pc_load     = 1'b0;
    instr_valid = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        pc_load   = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        // An ack in the final allowed cycle still counts as a successful fetch.
        if (imem_ack) begin
          state_nxt = EXEC;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ERR;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        // A halt instruction keeps the PC parked on its own address.
        pc_halt     = halt_instr;
        state_nxt   = halt_instr ? DONE : FETCH;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LOAD;
      end
      ERR: begin
        timeout = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == LOAD),
    .inc   (state == EXEC),
    .q     (instr_count)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == LOAD),
    .inc   ((state == FETCH) || (state == EXEC)),
    .q     (cycle_count)
  );

endmodule

// File: tb/tb_pc_run_controller.sv
// Scoreboard bench for pc_run_controller. Each run is planned as a list of
// per-instruction ack delays; the planner derives the expected event stream
// (load, instruction strobes, done/timeout, reset) from the run rules and
// queues it, while a negedge monitor pops and compares whenever the DUT shows
// an event. A second instance with 3-bit counters shares all stimulus.
module tb_pc_run_controller;

  localparam int AW       = 16;
  localparam int CW       = 16;
  localparam int CW3      = 3;
  localparam int MAX_WAIT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          halt_instr;
  logic          imem_ack;

  logic          imem_req, pc_halt, pc_load, instr_valid, done, timeout;
  logic [AW-1:0] load_addr;
  logic [CW-1:0] instr_count, cycle_count;

  logic           b_imem_req, b_pc_halt, b_pc_load, b_instr_valid, b_done, b_timeout;
  logic [AW-1:0]  b_load_addr;
  logic [CW3-1:0] b_instr_count, b_cycle_count;

  always #5 clk = ~clk;

  pc_run_controller #(.AW(AW), .CNT_W(CW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .halt_instr(halt_instr), .imem_ack(imem_ack), .imem_req(imem_req),
    .pc_halt(pc_halt), .pc_load(pc_load), .load_addr(load_addr),
    .instr_valid(instr_valid), .done(done), .timeout(timeout),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  pc_run_controller #(.AW(AW), .CNT_W(CW3), .MAX_WAIT(MAX_WAIT)) dut3 (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .halt_instr(halt_instr), .imem_ack(imem_ack), .imem_req(b_imem_req),
    .pc_halt(b_pc_halt), .pc_load(b_pc_load), .load_addr(b_load_addr),
    .instr_valid(b_instr_valid), .done(b_done), .timeout(b_timeout),
    .instr_count(b_instr_count), .cycle_count(b_cycle_count)
  );

  typedef enum int {EV_RESET, EV_LOAD, EV_INSTR, EV_DONE, EV_TIMEOUT} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    int            icnt;
    int            ccnt;
    logic [AW-1:0] addr;
    bit            halt;
  } ev_t;

  ev_t exp_q[$];
  int  plan_q[$];
  int  n_total = 0;
  int  n_bad   = 0;

  function automatic ev_t mk_ev(ev_kind_t k, int ic, int cc, logic [AW-1:0] a, bit h);
    ev_t e;
    e.kind = k; e.icnt = ic; e.ccnt = cc; e.addr = a; e.halt = h;
    return e;
  endfunction

  function automatic int sat(int v, int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  logic rst_at_edge = 1'b0;
  logic done_q = 1'b0;
  logic to_q   = 1'b0;

  always @(posedge clk) rst_at_edge <= reset;

  always @(negedge clk) begin : monitor
    ev_kind_t obs;
    ev_t      e;
    bit       fire;
    fire = 1'b1;
    obs  = EV_RESET;
    if (rst_at_edge)                       obs = EV_RESET;
    else if (pc_load === 1'b1)             obs = EV_LOAD;
    else if (instr_valid === 1'b1)         obs = EV_INSTR;
    else if (done === 1'b1 && !done_q)     obs = EV_DONE;
    else if (timeout === 1'b1 && !to_q)    obs = EV_TIMEOUT;
    else                                   fire = 1'b0;

    if (!rst_at_edge && imem_req === 1'b1) check("fetch_holds_pc", 32'(pc_halt), 32'd1);

    if (fire) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_event: got kind %0d want none at %0t", obs, $time);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(obs), 32'(e.kind));
        case (e.kind)
          EV_RESET: begin
            check("rst_imem_req", 32'(imem_req), 32'd0);
            check("rst_pc_halt", 32'(pc_halt), 32'd1);
            check("rst_outputs", {26'd0, pc_load, instr_valid, done, timeout, b_imem_req, b_pc_load}, 32'd0);
            check("rst_b_pc_halt", 32'(b_pc_halt), 32'd1);
            check("rst_load_addr", 32'(load_addr), 32'd0);
            check("rst_instr_count", 32'(instr_count), 32'd0);
            check("rst_cycle_count", 32'(cycle_count), 32'd0);
            check("rst_b_counts", {26'd0, b_instr_count, b_cycle_count}, 32'd0);
          end
          EV_LOAD: begin
            check("load_addr", 32'(load_addr), 32'(e.addr));
            check("load_b_addr", 32'(b_load_addr), 32'(e.addr));
            check("load_b_pc_load", 32'(b_pc_load), 32'd1);
            check("load_status_clear", {30'd0, done, timeout}, 32'd0);
          end
          EV_INSTR: begin
            check("exec_instr_count", 32'(instr_count), 32'(sat(e.icnt, CW)));
            check("exec_cycle_count", 32'(cycle_count), 32'(sat(e.ccnt, CW)));
            check("exec_b_instr_count", 32'(b_instr_count), 32'(sat(e.icnt, CW3)));
            check("exec_b_cycle_count", 32'(b_cycle_count), 32'(sat(e.ccnt, CW3)));
            check("exec_pc_halt", 32'(pc_halt), 32'(e.halt));
            check("exec_no_req", 32'(imem_req), 32'd0);
            check("exec_b_valid", 32'(b_instr_valid), 32'd1);
          end
          EV_DONE, EV_TIMEOUT: begin
            check("end_instr_count", 32'(instr_count), 32'(sat(e.icnt, CW)));
            check("end_cycle_count", 32'(cycle_count), 32'(sat(e.ccnt, CW)));
            check("end_b_instr_count", 32'(b_instr_count), 32'(sat(e.icnt, CW3)));
            check("end_b_cycle_count", 32'(b_cycle_count), 32'(sat(e.ccnt, CW3)));
            check("end_flags", {28'd0, done, timeout, b_done, b_timeout},
                  (e.kind == EV_DONE) ? 32'b1010 : 32'b0101);
            check("end_pc_halt", 32'(pc_halt), 32'd1);
            check("end_load_addr", 32'(load_addr), 32'(e.addr));
          end
          default: ;
        endcase
      end
    end
    done_q <= done;
    to_q   <= timeout;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; start/ack are left as set so "reset wins" is exercised.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back(mk_ev(EV_RESET, 0, 0, '0, 1'b0));
      tick();
    end
    reset    = 1'b0;
    start    = 1'b0;
    imem_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack   = 1'($urandom_range(1, 0));
      halt_instr = 1'($urandom_range(1, 0));
      tick();
    end
    imem_ack   = 1'b0;
    halt_instr = 1'b0;
  endtask

  // plan_q[i] = FETCH cycles without ack before instruction i is acked;
  // a value >= MAX_WAIT means never acked. The last planned instruction halts.
  // reset_at >= 0 applies reset in the first FETCH cycle of that instruction.
  task automatic do_run(input logic [AW-1:0] addr, input int reset_at);
    int  cyc, ic, i, k;
    bit  fin;
    int  last;
    last = plan_q.size() - 1;

    // Expected events, straight from the run rules.
    exp_q.push_back(mk_ev(EV_LOAD, 0, 0, addr, 1'b0));
    cyc = 0;
    ic  = 0;
    for (int j = 0; j <= last; j++) begin
      if (j == reset_at) break;
      if (plan_q[j] >= MAX_WAIT) begin
        cyc += MAX_WAIT;
        exp_q.push_back(mk_ev(EV_TIMEOUT, ic, cyc, addr, 1'b0));
        break;
      end
      cyc += plan_q[j] + 1;
      exp_q.push_back(mk_ev(EV_INSTR, ic, cyc, addr, j == last));
      cyc += 1;
      ic  += 1;
      if (j == last) exp_q.push_back(mk_ev(EV_DONE, ic, cyc, addr, 1'b0));
    end

    // Drive: memory and decode behaviour plus ignored-start/ack noise.
    start      = 1'b1;
    start_addr = addr;
    tick();
    start      = 1'b0;
    start_addr = AW'($urandom);
    i   = 0;
    k   = 0;
    fin = 1'b0;
    for (int budget = 0; budget < 400 && !fin; budget++) begin
      imem_ack   = 1'b0;
      halt_instr = 1'b0;
      start      = 1'b0;
      if (imem_req && i == reset_at) begin
        imem_ack = 1'($urandom_range(1, 0));
        start    = 1'b1;
        do_reset(1);
        fin = 1'b1;
      end else if (imem_req) begin
        if (i <= last && k == plan_q[i]) imem_ack = 1'b1;
        k++;
        halt_instr = 1'($urandom_range(1, 0));
        start      = ($urandom_range(7, 0) == 0);
      end else if (instr_valid) begin
        halt_instr = (i >= last);
        imem_ack   = 1'($urandom_range(1, 0));
        start      = ($urandom_range(3, 0) == 0);
        i++;
        k = 0;
      end else if (done || timeout) begin
        fin = 1'b1;
      end else begin
        start = ($urandom_range(3, 0) == 0);
      end
      if (!fin) tick();
    end
    imem_ack   = 1'b0;
    halt_instr = 1'b0;
    start      = 1'b0;
    if (!fin) begin
      fail_now("run_budget");
      exp_q.delete();
      do_reset(1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    halt_instr = 1'b0;
    imem_ack   = 1'b0;
    tick();

    // Reset held two cycles.
    do_reset(2);
    idle(2);

    // Four instructions acked in their first FETCH cycle, halt on the fourth.
    plan_q = '{0, 0, 0, 0};
    do_run(16'h0010, -1);
    idle(3);

    // Fetch never acked: timeout, then restart from ERR.
    plan_q = '{MAX_WAIT};
    do_run(16'h0200, -1);
    idle(2);
    plan_q = '{1, 0};
    do_run(16'h0300, -1);

    // Ack in the last allowed FETCH cycle still executes.
    plan_q = '{MAX_WAIT - 1, 0, MAX_WAIT - 1};
    do_run(16'h0400, -1);

    // Reset while a fetch is outstanding (start and ack asserted with it).
    plan_q = '{1, 2, 0, 0};
    do_run(16'h0500, 2);
    idle(3);

    // Long program: 3-bit counters saturate.
    plan_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_run(16'h0600, -1);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      int n;
      int rst_at;
      n = $urandom_range(12, 1);
      plan_q.delete();
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(15, 0) == 0) plan_q.push_back(MAX_WAIT);
        else                            plan_q.push_back($urandom_range(MAX_WAIT - 1, 0));
      end
      rst_at = ($urandom_range(5, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
      do_run(AW'($urandom), rst_at);
      idle($urandom_range(3, 0));
    end

    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
